cpu_control_fsm: RTL



---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/cpu_control_fsm_if.sv | 30 +++
 rtl/cpu_control_fsm_imm_gen.sv | 28 ++
 rtl/cpu_control_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: step-counter encodings,
// RV64 opcode constants, ALU operation codes, the halt word and the
// instruction-class decoder that the FSM and its outputs are steered by.
package cpu_ctrl_pkg;

  // Step-counter encodings, visible to the register file on o_state.
  localparam logic [4:0] S_IF_REQ   = 5'd0;
  localparam logic [4:0] S_IF_WAIT  = 5'd1;
  localparam logic [4:0] S_ID       = 5'd2;
  localparam logic [4:0] S_RF_RD    = 5'd3;
  localparam logic [4:0] S_EX       = 5'd4;
  localparam logic [4:0] S_MEM_REQ  = 5'd5;
  localparam logic [4:0] S_MEM_WAIT = 5'd6;
  localparam logic [4:0] S_LD_CAP   = 5'd7;
  localparam logic [4:0] S_BR       = 5'd8;
  localparam logic [4:0] S_PC_NEXT  = 5'd9;
  localparam logic [4:0] S_WB       = 5'd10;
  localparam logic [4:0] S_HALT     = 5'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_LD, CLS_SD, CLS_BR, CLS_ALU_R, CLS_ALU_I, CLS_HALT
  } inst_class_e;

  // Only beq/bne (funct3 000/001) count as branches; other branch
  // encodings fall through to the no-op path.
  function automatic inst_class_e decode_class(input logic [31:0] inst);
    inst_class_e cls;
    cls = CLS_NOP;
    if (inst == HALT_WORD) begin
      cls = CLS_HALT;
    end else begin
      case (inst[6:0])
        OP_LOAD:   cls = CLS_LD;
        OP_STORE:  cls = CLS_SD;
        OP_BRANCH: if (inst[14:13] == 2'b00) cls = CLS_BR;
        OP_ALU_R:  cls = CLS_ALU_R;
        OP_ALU_I:  cls = CLS_ALU_I;
        default:   cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction-fetch and data-memory handshake bundle of the control unit.
//   o_i_valid_addr / o_i_addr : one-cycle fetch request and address (PC)
//   i_i_valid_inst / i_i_inst : instruction-return strobe and word
//   o_d_req                   : one-cycle data-memory request
//   o_MemRead / o_MemWrite    : access type, held from ID to PC_NEXT
//   i_d_valid                 : data-memory completion strobe
// master = control unit, slave = memory side.
interface cpu_control_fsm_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              o_i_valid_addr;
  logic [ADDR_W-1:0] o_i_addr;
  logic              i_i_valid_inst;
  logic [INST_W-1:0] i_i_inst;
  logic              o_d_req;
  logic              o_MemRead;
  logic              o_MemWrite;
  logic              i_d_valid;

  modport master (
    output o_i_valid_addr, o_i_addr, o_d_req, o_MemRead, o_MemWrite,
    input  i_i_valid_inst, i_i_inst, i_d_valid
  );

  modport slave (
    input  o_i_valid_addr, o_i_addr, o_d_req, o_MemRead, o_MemWrite,
    output i_i_valid_inst, i_i_inst, i_d_valid
  );
endinterface

// File: rtl/cpu_control_fsm_imm_gen.sv
// imm_gen: combinational instruction -> sign-extended immediate.
//   inst : latched instruction word
//   imm  : I-type (ld, ALU-immediate), S-type (sd) or B-type (branch)
//          immediate, bit 31 sign-extended; zero for all other opcodes.
module imm_gen
  import cpu_ctrl_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int DATA_W = 64
) (
  input  logic [INST_W-1:0] inst,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    imm = '0;
    case (inst[6:0])
      OP_LOAD, OP_ALU_I: imm = {{(DATA_W-12){inst[31]}}, inst[31:20]};
      OP_STORE:          imm = {{(DATA_W-12){inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:         imm = {{(DATA_W-13){inst[31]}}, inst[31], inst[7],
                                inst[30:25], inst[11:8], 1'b0};
      default:           imm = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit for the RV64 core. Fetches over
// the bus handshake, decodes the latched instruction, steps o_state for the
// register file (write-back in WB only), owns the PC and branch resolution.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   bus (master)        : fetch and data-memory handshake
//   i_zero              : ALU zero flag, sampled in BR
//   o_read_register1/2, o_write_register : rs1 / rs2 / rd fields
//   o_RegWrite          : rd write enable, asserted in WB only
//   o_state             : current step
//   o_imm, o_alu_ctrl, o_alu_src : immediate and ALU controls
//   o_pc                : current PC
//   o_finish            : sticky halt flag
// Optional: define CTRL_WAIT_TIMEOUT_EN to halt after 256 strobe-less cycles
// in IF_WAIT or MEM_WAIT.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DATA_W = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  cpu_control_fsm_if.master  bus,
  input  logic               i_zero,
  output logic [4:0]         o_read_register1,
  output logic [4:0]         o_read_register2,
  output logic [4:0]         o_write_register,
  output logic               o_RegWrite,
  output logic [4:0]         o_state,
  output logic [DATA_W-1:0]  o_imm,
  output logic [3:0]         o_alu_ctrl,
  output logic               o_alu_src,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_finish
);

  logic [4:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic              taken_q;
  logic              timeout;
  inst_class_e       cls;
  logic [2:0]        funct3;

  assign cls    = decode_class(inst_q[31:0]);
  assign funct3 = inst_q[14:12];

  imm_gen #(.INST_W(INST_W), .DATA_W(DATA_W)) u_imm_gen (
    .inst (inst_q),
    .imm  (o_imm)
  );

`ifdef CTRL_WAIT_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Counter holds 255 during the 256th strobe-less waiting cycle.
  assign timeout = (wait_cnt_q == 8'hFF) &&
                   ((state_q == S_IF_WAIT  && !bus.i_i_valid_inst) ||
                    (state_q == S_MEM_WAIT && !bus.i_d_valid));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wait_cnt_q <= 8'd0;
    else if (state_q == S_IF_WAIT || state_q == S_MEM_WAIT)
      wait_cnt_q <= wait_cnt_q + 8'd1;
    else
      wait_cnt_q <= 8'd0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF_REQ:   state_d = S_IF_WAIT;
      S_IF_WAIT:  if (bus.i_i_valid_inst) state_d = S_ID;
      S_ID: begin
        case (cls)
          CLS_HALT: state_d = S_HALT;
          CLS_NOP:  state_d = S_PC_NEXT;
          default:  state_d = S_RF_RD;
        endcase
      end
      S_RF_RD:    state_d = S_EX;
      S_EX: begin
        case (cls)
          CLS_LD, CLS_SD: state_d = S_MEM_REQ;
          CLS_BR:         state_d = S_BR;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM_REQ:  state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (bus.i_d_valid) state_d = (cls == CLS_LD) ? S_LD_CAP : S_PC_NEXT;
      S_LD_CAP:   state_d = S_WB;
      S_BR:       state_d = S_PC_NEXT;
      S_WB:       state_d = S_PC_NEXT;
      S_PC_NEXT:  state_d = S_IF_REQ;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IF_REQ;
    endcase
    if (timeout) state_d = S_HALT;
  end

  // The latched instruction is reset too: every decode output derives from
  // it and must read as zero while reset is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IF_REQ;
      pc_q    <= '0;
      inst_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == S_IF_WAIT && bus.i_i_valid_inst) inst_q <= bus.i_i_inst;
      // funct3[0]: 0 = beq (taken on zero), 1 = bne (taken on non-zero).
      if (state_q == S_BR) taken_q <= inst_q[12] ? !i_zero : i_zero;
      if (state_q == S_PC_NEXT)
        pc_q <= (cls == CLS_BR && taken_q) ? pc_q + o_imm[ADDR_W-1:0]
                                           : pc_q + ADDR_W'(4);
    end
  end

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (cls)
      CLS_ALU_R: begin
        case (funct3)
          3'b000:  o_alu_ctrl = inst_q[30] ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_ctrl = ALU_AND;
          3'b110:  o_alu_ctrl = ALU_OR;
          3'b100:  o_alu_ctrl = ALU_XOR;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_ALU_I: begin
        case (funct3)
          3'b111:  o_alu_ctrl = ALU_AND;
          3'b110:  o_alu_ctrl = ALU_OR;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b101:  o_alu_ctrl = ALU_SRL;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      CLS_BR:  o_alu_ctrl = ALU_SUB;
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

  // Reset parks the FSM in IF_REQ; gating with i_rst_n keeps the fetch
  // strobe low while reset is held and high from the first cycle after.
  assign bus.o_i_valid_addr = i_rst_n && (state_q == S_IF_REQ);
  assign bus.o_i_addr       = pc_q;
  assign bus.o_d_req        = (state_q == S_MEM_REQ);
  // ID..WB spans every step between decode and PC_NEXT for ld/sd.
  assign bus.o_MemRead      = (state_q >= S_ID) && (state_q <= S_WB) && (cls == CLS_LD);
  assign bus.o_MemWrite     = (state_q >= S_ID) && (state_q <= S_WB) && (cls == CLS_SD);

  assign o_read_register1 = inst_q[19:15];
  assign o_read_register2 = inst_q[24:20];
  assign o_write_register = inst_q[11:7];
  assign o_RegWrite       = (state_q == S_WB) && (inst_q[11:7] != 5'd0) &&
                            (cls inside {CLS_LD, CLS_ALU_R, CLS_ALU_I});
  assign o_alu_src        = cls inside {CLS_LD, CLS_SD, CLS_ALU_I};
  assign o_state          = state_q;
  assign o_pc             = pc_q;
  assign o_finish         = (state_q == S_HALT);

endmodule
